// File: rtl/i2s_dac_tx.sv
// ============================================================================
// Module   : i2s_dac_tx
// Purpose  : I2S transmitter to a DAC codec, fed by a one-deep sample buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_dac_tx #(
   parameter int WD   = 16,
   parameter int SLOT = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          bclk_fall_i,
   input  logic          sample_valid_i,
   input  logic [WD-1:0] left_i,
   input  logic [WD-1:0] right_i,
   output logic          sample_ready_o,
   output logic          daclrc_o,
   output logic          dacdat_o,
   output logic          underrun_o
);

   localparam int            CW     = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(SLOT - 1);
   localparam logic [CW-1:0] C_WD   = CW'(WD);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LEFT  = 2'd1,
      S_RIGHT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_bit_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_full;
   logic [WD-1:0] r_buf_l;
   logic [WD-1:0] r_buf_r;
   logic [WD-1:0] r_tx_l;
   logic [WD-1:0] r_tx_r;
   logic          r_daclrc;
   logic          r_dacdat;
   logic          r_underrun;

   logic          w_tick;
   logic          w_load;
   logic          w_accept;
   logic [WD-1:0] w_word;
   logic [WD-1:0] w_shift;
   logic          w_bit;

   assign w_tick   = en_i & bclk_fall_i;
   assign w_accept = sample_valid_i & ~r_full;

   // Next slot position assuming a tick; w_load flags the start of a frame.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_bit_cnt;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_LEFT;
            w_cnt_nxt   = '0;
            w_load      = 1'b1;
         end
         S_LEFT: begin
            if (r_bit_cnt != C_LAST) begin
               w_cnt_nxt = r_bit_cnt + CW'(1);
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_RIGHT;
            end
         end
         S_RIGHT: begin
            if (r_bit_cnt != C_LAST) begin
               w_cnt_nxt = r_bit_cnt + CW'(1);
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_LEFT;
               w_load      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Bit n of a slot carries word[WD-n]: one BCLK of MSB delay, then zero pad.
   assign w_word  = (w_state_nxt == S_RIGHT) ? r_tx_r : r_tx_l;
   assign w_shift = w_word << (w_cnt_nxt - CW'(1));
   assign w_bit   = (w_cnt_nxt != '0) && (w_cnt_nxt <= C_WD) && w_shift[WD-1];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_full     <= 1'b0;
         r_buf_l    <= '0;
         r_buf_r    <= '0;
         r_tx_l     <= '0;
         r_tx_r     <= '0;
         r_daclrc   <= 1'b0;
         r_dacdat   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;

         if (!en_i) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_daclrc  <= 1'b0;
            r_dacdat  <= 1'b0;
         end else if (bclk_fall_i) begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_daclrc  <= (w_state_nxt == S_RIGHT);
            r_dacdat  <= w_bit;
         end

         // Frame load has priority; a pair offered in that cycle bypasses the buffer.
         if (w_tick && w_load) begin
            if (r_full) begin
               r_tx_l <= r_buf_l;
               r_tx_r <= r_buf_r;
               r_full <= 1'b0;
            end else if (sample_valid_i) begin
               r_tx_l <= left_i;
               r_tx_r <= right_i;
            end else begin
               r_tx_l     <= '0;
               r_tx_r     <= '0;
               r_underrun <= 1'b1;
            end
         end else if (w_accept) begin
            r_buf_l <= left_i;
            r_buf_r <= right_i;
            r_full  <= 1'b1;
         end
      end
   end

   assign sample_ready_o = ~r_full;
   assign daclrc_o       = r_daclrc;
   assign dacdat_o       = r_dacdat;
   assign underrun_o     = r_underrun;

endmodule

`default_nettype wire

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter WD, default 16, sample width in bits.
REQ-002 SHALL have parameter SLOT, default 32, BCLK periods per channel slot; SLOT >= WD+1.
REQ-003 SHALL have port clk_i  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en_i  input  1  transmit enable; low forces IDLE.
REQ-006 SHALL have port bclk_fall_i  input  1  one-clk_i pulse per BCLK falling edge (tick).
REQ-007 SHALL have port sample_valid_i  input  1  left_i/right_i pair valid.
REQ-008 SHALL have port left_i  input  WD  left-channel sample, two's complement.
REQ-009 SHALL have port right_i  input  WD  right-channel sample, two's complement.
REQ-010 SHALL have port sample_ready_o  output  1  one-deep buffer empty; pair accepted when valid and ready are both high.
REQ-011 SHALL have port daclrc_o  output  1  I2S word select to the codec; 0 = left, 1 = right.
REQ-012 SHALL have port dacdat_o  output  1  I2S serial data to the codec, MSB first.
REQ-013 SHALL have port underrun_o  output  1  one-clk_i pulse when a frame starts with no sample available.

Function
REQ-014 SHALL implement the FSM states IDLE, LEFT and RIGHT, a bit counter bit_cnt in 0..SLOT-1, a one-deep pair buffer with a full flag, and tx_l/tx_r frame registers.
REQ-015 SHALL advance all counters, states and serial outputs only on clk_i edges where bclk_fall_i=1 and en_i=1; the handshake operates on every clk_i edge.
REQ-016 SHALL, in IDLE on a tick, enter LEFT with bit_cnt=0 and perform a frame load.
REQ-017 SHALL, in LEFT or RIGHT on a tick, increment bit_cnt when bit_cnt<SLOT-1; otherwise clear bit_cnt to 0 and toggle state (LEFT->RIGHT; RIGHT->LEFT with frame load).
REQ-018 SHALL register daclrc_o as 1 in RIGHT and 0 in LEFT and IDLE, so it changes on the same tick as the state.
REQ-019 SHALL update dacdat_o on each tick: bit [WD-n] of the current channel word when the new bit_cnt n is in 1..WD, else 0 (I2S one-BCLK MSB delay, zero padding).
REQ-020 SHALL, on a frame load with the buffer full, copy the buffer to tx_l/tx_r and clear the full flag.
REQ-021 SHALL, on a frame load with the buffer empty and sample_valid_i=1 in the same cycle, load left_i/right_i directly into tx_l/tx_r, assert no underrun, and leave the buffer empty.
REQ-022 SHALL, on a frame load with the buffer empty and sample_valid_i=0, load zeros into tx_l/tx_r and pulse underrun_o for one clk_i cycle.
REQ-023 SHALL drive sample_ready_o = NOT full flag.
REQ-024 SHALL, on an accepted pair not consumed by REQ-021, store it in the buffer and set the full flag.
REQ-025 SHALL hold sample_ready_o low during a cycle in which the full flag is cleared by a frame load; a new pair is accepted from the next cycle.
REQ-026 SHALL, when en_i=0, on the next clk_i edge enter IDLE, clear bit_cnt, daclrc_o and dacdat_o, retain the buffer and its full flag, and keep accepting one pair.
REQ-027 SHALL ignore bclk_fall_i while en_i=0, and SHALL treat a mid-frame drop of en_i as an abort with no completion of the partial frame.

Reset
REQ-028 SHALL, when rst_ni=0 at a clk_i edge, set state=IDLE, bit_cnt=0, full flag=0, tx_l=tx_r=0, daclrc_o=0, dacdat_o=0 and underrun_o=0, giving sample_ready_o=1.
REQ-029 SHALL give reset priority over en_i, ticks and the handshake, including mid-frame.

Verification (WD=16, SLOT=32)
REQ-030 SHALL test single frame: accept left=16'hA5F0 and right=16'h0F0F, then ticks -> daclrc_o=0 for 32 ticks and 1 for 32 ticks; dacdat_o=0, then 1010010111110000, then 15 zeros in the left slot; the same pattern with 0000111100001111 in the right slot.
REQ-031 SHALL test underrun: no sample before the frame load -> underrun_o pulses exactly once, dacdat_o stays 0 for 64 ticks, daclrc_o still toggles.
REQ-032 SHALL test back-pressure: buffer full with valid held -> sample_ready_o=0 until the next RIGHT->LEFT load; the second pair is accepted the cycle after the load and transmitted in the following frame.
REQ-033 SHALL test bypass: buffer empty with valid asserted in the frame-load cycle -> no underrun, and that pair is transmitted in the current frame.
REQ-034 SHALL test abort: en_i dropped at bit_cnt=7 of LEFT -> next cycle daclrc_o=0, dacdat_o=0, state IDLE; re-enabling restarts at LEFT bit_cnt=0 with a frame load.
REQ-035 SHALL test reset mid-frame: rst_ni=0 for one cycle during RIGHT with the buffer full -> all outputs 0, sample_ready_o=1, buffered pair discarded.
